deserializer_1_to_10_ddr: RTL

DESERIALIZER_1_TO_10_DDR -- requirements
Module: deserializer_1_to_10_ddr

---
 rtl/deser_pkg.sv | 27 ++
 rtl/word_aligner.sv | 90 +++++++++
 rtl/deserializer_1_to_10_ddr.sv | 94 +++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the 1:10 DDR deserializer: word width, K28.5
// comma codewords, alignment FSM state encoding and a comma compare helper.
package deser_pkg;

    localparam int WORD_W = 10;

    // K28.5 codewords, bit0 = first bit on the line.
    localparam logic [WORD_W-1:0] COMMA_P_DEF = 10'h17C;
    localparam logic [WORD_W-1:0] COMMA_N_DEF = 10'h283;

    // A word is collected over five bit pairs (phase 0..4).
    localparam logic [2:0] PHASE_LAST  = 3'd4;
    // Bit offset runs 0..9.
    localparam logic [3:0] OFFSET_LAST = 4'd9;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    function automatic logic is_comma(input logic [WORD_W-1:0] word,
                                      input logic [WORD_W-1:0] comma_p,
                                      input logic [WORD_W-1:0] comma_n);
        return (word == comma_p) || (word == comma_n);
    endfunction

endpackage

// File: rtl/word_aligner.sv
// Comma-based word alignment FSM. Watches every recovered word, requests a
// one-bit slip after TIMEOUT comma-free words while searching, and reports
// lock after LOCK_CNT commas. Built only with DESER_AUTO_ALIGN_EN defined.
`ifdef DESER_AUTO_ALIGN_EN
module word_aligner
    import deser_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA_P  = COMMA_P_DEF,
    parameter logic [WORD_W-1:0] COMMA_N  = COMMA_N_DEF,
    parameter int                LOCK_CNT = 4,
    parameter int                TIMEOUT  = 32
) (
    input  logic              fast_clk_i,
    input  logic              rst,
    input  logic [WORD_W-1:0] word,
    input  logic              strobe,
    output logic              slip,
    output logic              locked
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    // The count that, incremented once more, reaches its limit.
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

    align_state_t   state_q, state_d;
    logic [MW-1:0]  match_q, match_d;
    logic [IW-1:0]  idle_q,  idle_d;
    logic           comma;

    assign comma  = is_comma(word, COMMA_P, COMMA_N);
    assign locked = (state_q == LOCKED);

    // State and counter registers.
    always_ff @(posedge fast_clk_i) begin
        if (rst) begin
            state_q <= SEARCH;
            match_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            idle_q  <= idle_d;
        end
    end

    // Next state: commas win over the timeout; counters never pass their limit.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        idle_d  = idle_q;
        slip    = 1'b0;
        if (strobe) begin
            case (state_q)
                SEARCH: begin
                    if (comma) begin
                        if (match_q >= MATCH_LAST) begin
                            state_d = LOCKED;
                            match_d = '0;
                            idle_d  = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else if (idle_q >= IDLE_LAST) begin
                        slip    = 1'b1;
                        match_d = '0;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (comma) begin
                        idle_d = '0;
                    end else if (idle_q >= IDLE_LAST) begin
                        state_d = SEARCH;
                        match_d = '0;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

endmodule
`endif

// File: rtl/deserializer_1_to_10_ddr.sv
// 1:10 DDR deserializer: collects five bit pairs per word into a 20-bit
// history, emits a word every fifth cycle at a selectable bit offset.
// Build macro DESER_AUTO_ALIGN_EN: automatic comma alignment (bitslip_i
// ignored); otherwise bitslip_i slips one bit per high cycle.
module deserializer_1_to_10_ddr
    import deser_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA_P  = COMMA_P_DEF,
    parameter logic [WORD_W-1:0] COMMA_N  = COMMA_N_DEF,
    parameter int                LOCK_CNT = 4,
    parameter int                TIMEOUT  = 32
) (
    input  logic              fast_clk_i,
    input  logic              rst,
    input  logic [1:0]        dat_i,
    input  logic              bitslip_i,
    output logic [WORD_W-1:0] dat_o,
    output logic              dat_valid_o,
    output logic              locked_o
);

    localparam int HIST_W = 2 * WORD_W;

    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_nxt;
    logic [HIST_W-1:0] hist_shifted;
    logic [4:0]        shamt;
    logic [WORD_W-1:0] word_nxt;
    logic [2:0]        phase_q;
    logic [3:0]        offset_q;
    logic              strobe;
    logic              slip;

    // Newest pair enters at the top, so history bit 19 is the latest bit and
    // lower indices are older; bit order inside a word stays oldest-first.
    assign hist_nxt = {dat_i, hist_q[HIST_W-1:2]};
    assign strobe   = (phase_q == PHASE_LAST);

    // Word window: offset 0 is the ten newest bits (including the pair
    // arriving now); each offset step moves the window one bit earlier.
    always_comb begin
        shamt        = 5'(WORD_W) - {1'b0, offset_q};
        hist_shifted = hist_nxt >> shamt;
        word_nxt     = hist_shifted[WORD_W-1:0];
    end

    // History, phase, offset and output word registers.
    always_ff @(posedge fast_clk_i) begin
        if (rst) begin
            hist_q      <= '0;
            phase_q     <= '0;
            offset_q    <= '0;
            dat_o       <= '0;
            dat_valid_o <= 1'b0;
        end else begin
            hist_q      <= hist_nxt;
            phase_q     <= strobe ? 3'd0 : phase_q + 3'd1;
            dat_valid_o <= strobe;
            if (strobe) begin
                dat_o <= word_nxt;
            end
            if (slip) begin
                offset_q <= (offset_q == OFFSET_LAST) ? 4'd0 : offset_q + 4'd1;
            end
        end
    end

`ifdef DESER_AUTO_ALIGN_EN
    logic unused_bitslip;
    assign unused_bitslip = bitslip_i;

    word_aligner #(
        .COMMA_P  (COMMA_P),
        .COMMA_N  (COMMA_N),
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT)
    ) u_word_aligner (
        .fast_clk_i (fast_clk_i),
        .rst        (rst),
        .word       (word_nxt),
        .strobe     (strobe),
        .slip       (slip),
        .locked     (locked_o)
    );
`else
    // Alignment settings have no effect without the aligner.
    logic unused_cfg;
    assign unused_cfg = ^{COMMA_P, COMMA_N} ^ (LOCK_CNT > 0) ^ (TIMEOUT > 0);

    assign slip     = bitslip_i;
    assign locked_o = 1'b0;
`endif

endmodule
